// File: rtl/tgl_dec_pkg.sv
// rtl/tgl_dec_pkg.sv - shared FSM encoding, default widths and helper width function
package tgl_dec_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } tgl_state_e;

  localparam int PEND_W_DEF   = 3;
  localparam int CNT_W_DEF    = 8;
  localparam int FILT_CYC_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Glitch-filter counter must hold 0..FILT_CYC.
  function automatic int filt_cnt_w(input int filt_cyc);
    int w;
    w = clog2(filt_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tgl_sync2.sv
// rtl/tgl_sync2.sv - two-flop synchroniser for the asynchronous toggle line
module tgl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q1,
  output logic q2
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end

endmodule

// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - toggle-line event decoder with pending counter and handshake
// Optional glitch filter on the synchronised level: TGL_GLITCH_FILTER_EN.
module toggle_event_decoder
  import tgl_dec_pkg::*;
#(
  parameter int PEND_W   = PEND_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
`ifdef TGL_GLITCH_FILTER_EN
  ,
  parameter int FILT_CYC = FILT_CYC_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En,
  input  logic              tgl_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend,
  output logic [CNT_W-1:0]  evt_count,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  tgl_state_e state;
  tgl_state_e state_nxt;
  logic       track;
  logic       run;

  logic sync1;
  logic sync2;
  logic lvl;
  logic prev;
  logic det;
  logic inc;
  logic dec;

  tgl_sync2 u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (tgl_in),
    .q1   (sync1),
    .q2   (sync2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_FILL;
      ST_FILL: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    track = 1'b1;
    run   = 1'b0;
    case (state)
      ST_RUN:  begin track = 1'b0; run = 1'b1; end
      default: begin track = 1'b1; run = 1'b0; end
    endcase
  end

  // While tracking, seed from sync1: it is the value sync2 presents on the first RUN cycle,
  // so a line already high at reset release is absorbed as the idle level.
`ifdef TGL_GLITCH_FILTER_EN
  localparam int FCW = filt_cnt_w(FILT_CYC);

  logic           flt;
  logic [FCW-1:0] fcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt  <= 1'b0;
      fcnt <= '0;
    end else if (track) begin
      flt  <= sync1;
      fcnt <= '0;
    end else if (sync2 != flt) begin
      if (fcnt == FCW'(FILT_CYC - 1)) begin
        flt  <= sync2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign lvl = flt;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     prev <= 1'b0;
    else if (track) prev <= sync1;
    else            prev <= lvl;
  end

  assign det       = run && En && (lvl != prev);
  assign evt_valid = (pend != '0);
  assign inc       = det;
  assign dec       = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      evt_count <= '0;
      ovf       <= 1'b0;
    end else begin
      if (inc && !dec) begin
        if (pend != PEND_MAX) pend <= pend + 1'b1;
      end else if (!inc && dec) begin
        pend <= pend - 1'b1;
      end

      if (inc) evt_count <= evt_count + 1'b1;

      // A drop in the same cycle as clr_ovf must stay visible.
      if (inc && !dec && (pend == PEND_MAX)) ovf <= 1'b1;
      else if (clr_ovf)                      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - scoreboard bench for toggle_event_decoder
module tb_toggle_event_decoder;

  logic       clk;
  logic       reset;
  logic       En;
  logic       tgl_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] pend;
  logic [7:0] evt_count;
  logic       ovf;
  logic       clr_ovf;

  int n_pass  = 0;
  int n_total = 0;

`ifdef TGL_GLITCH_FILTER_EN
  localparam int SP = 6;
  localparam int W  = 14;
`else
  localparam int SP = 1;
  localparam int W  = 8;
`endif

  toggle_event_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .En       (En),
    .tgl_in   (tgl_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .pend     (pend),
    .evt_count(evt_count),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    cyc();
    reset     = 1'b0;
    tgl_in    = lvl;
    En        = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    repeat (4) cyc();
  endtask

`ifndef TGL_GLITCH_FILTER_EN
  // Reference: a change between consecutive post-reset line samples s[k-1] -> s[k]
  // becomes an event two edges after s[k] was taken, if En is high then.
  typedef struct {
    int pend;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t sbq[$];
  bit   hist[$];
  int   m_edges;
  int   m_pend;
  int   m_cnt;
  bit   m_ovf;
  bit   m_ev;
  bit   m_dec;
  exp_t m_e;
  exp_t mon_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edges = 0;
      hist.delete();
      sbq.delete();
      m_pend = 0;
      m_cnt  = 0;
      m_ovf  = 0;
    end else begin
      m_edges++;
      hist.push_back(tgl_in);
      m_ev  = (m_edges >= 4) && (hist[m_edges-3] != hist[m_edges-4]) && En;
      m_dec = (m_pend > 0) && evt_ready;
      if (m_ev && !m_dec && m_pend == 7) m_ovf = 1;
      else if (clr_ovf)                  m_ovf = 0;
      if (m_ev && !m_dec && m_pend < 7) m_pend++;
      else if (!m_ev && m_dec)          m_pend--;
      if (m_ev) m_cnt = (m_cnt + 1) % 256;
      m_e.pend = m_pend;
      m_e.cnt  = m_cnt;
      m_e.ovf  = m_ovf;
      sbq.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (reset && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_total++;
      if (int'(pend) == mon_e.pend && evt_valid == (mon_e.pend != 0) &&
          int'(evt_count) == mon_e.cnt && ovf == mon_e.ovf)
        n_pass++;
      else
        $display("FAIL scoreboard t=%0t: pend=%0d valid=%0b cnt=%0d ovf=%0b expected pend=%0d cnt=%0d ovf=%0b",
                 $time, pend, evt_valid, evt_count, ovf, mon_e.pend, mon_e.cnt, mon_e.ovf);
    end
  end
`endif

  initial begin
    int k;
    int seq[4];
    reset     = 1'b0;
    En        = 1'b1;
    tgl_in    = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    // 1: line high through reset release
    do_reset(1'b1);
    repeat (10) cyc();
    chk("t1_pend", int'(pend), 0);
    chk("t1_count", int'(evt_count), 0);
    chk("t1_valid", int'(evt_valid), 0);

`ifndef TGL_GLITCH_FILTER_EN
    // 2: latency
    do_reset(1'b0);
    tgl_in = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (evt_valid && k == 0) k = i;
    end
    chk("t2_latency", k, 3);
    chk("t2_pend", int'(pend), 1);
    chk("t2_count", int'(evt_count), 1);

    // 3: overflow and clear
    do_reset(1'b0);
    repeat (9) begin
      tgl_in = ~tgl_in;
      cyc();
      cyc();
    end
    repeat (4) cyc();
    chk("t3_pend", int'(pend), 7);
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_count", int'(evt_count), 9);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    cyc();
    chk("t3_ovf_clr", int'(ovf), 0);
    chk("t3_pend_hold", int'(pend), 7);

    // 4: drain while one event arrives (inc&dec cycle)
    do_reset(1'b0);
    repeat (3) begin
      tgl_in = ~tgl_in;
      cyc();
      cyc();
    end
    repeat (4) cyc();
    chk("t4_pend_start", int'(pend), 3);
    tgl_in = ~tgl_in;
    cyc();
    chk("t4_pend_e1", int'(pend), 3);
    evt_ready = 1'b1;
    seq = '{2, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t4_pend_seq%0d", i), int'(pend), seq[i]);
    end
    chk("t4_valid_drop", int'(evt_valid), 0);
    evt_ready = 1'b0;

    // 5: En=0 discards toggles, no backlog
    En = 1'b0;
    repeat (4) begin
      tgl_in = ~tgl_in;
      cyc();
      cyc();
    end
    repeat (4) cyc();
    En = 1'b1;
    cyc();
    chk("t5_pend_off", int'(pend), 0);
    chk("t5_count_off", int'(evt_count), 4);
    tgl_in = ~tgl_in;
    repeat (4) cyc();
    chk("t5_pend_on", int'(pend), 1);
    chk("t5_count_on", int'(evt_count), 5);

    // randomized traffic against the reference model
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2, 0) == 0) tgl_in = ~tgl_in;
      evt_ready = ($urandom_range(2, 0) == 0);
      En        = ($urandom_range(7, 0) != 0);
      clr_ovf   = ($urandom_range(15, 0) == 0);
      if ($urandom_range(699, 0) == 0) begin
        reset = 1'b0;
        cyc();
        reset = 1'b1;
      end
      cyc();
    end
    En        = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
`else
    // 6: glitch filter
    do_reset(1'b0);
    tgl_in = 1'b1;
    cyc();
    cyc();
    tgl_in = 1'b0;
    repeat (12) cyc();
    chk("t6_pulse_pend", int'(pend), 0);
    chk("t6_pulse_count", int'(evt_count), 0);
    tgl_in = 1'b1;
    repeat (18) cyc();
    chk("t6_level_pend", int'(pend), 1);
    chk("t6_level_count", int'(evt_count), 1);
`endif

    // evt_count wrap
    do_reset(1'b0);
    evt_ready = 1'b1;
    repeat (255) begin
      tgl_in = ~tgl_in;
      repeat (SP) cyc();
    end
    repeat (W) cyc();
    chk("wrap_255", int'(evt_count), 255);
    tgl_in = ~tgl_in;
    repeat (W) cyc();
    chk("wrap_0", int'(evt_count), 0);
    chk("wrap_ovf", int'(ovf), 0);
    evt_ready = 1'b0;

    // reset mid-operation
    do_reset(1'b0);
    repeat (5) begin
      tgl_in = ~tgl_in;
      repeat (SP + 1) cyc();
    end
    repeat (W) cyc();
    chk("rst_pend_before", int'(pend), 5);
    reset = 1'b0;
    #1;
    chk("rst_pend_now", int'(pend), 0);
    chk("rst_valid_now", int'(evt_valid), 0);
    chk("rst_count_now", int'(evt_count), 0);
    cyc();
    reset = 1'b1;
    repeat (W) cyc();
    chk("rst_pend_after", int'(pend), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
